// File: rtl/conv_rr_sched_if.sv
// conv_rr_sched bus bundle: requester streams,
// shared conv engine ports and tagged result stream.
interface conv_rr_sched_if #(
  parameter int N  = 2,
  parameter int W  = 11,
  parameter int IW = (N > 1) ? $clog2(N) : 1
);
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [W-1:0]   e_x_data;
  logic           e_x_valid;
  logic           e_x_ready;
  logic [W-1:0]   e_y_data;
  logic           e_y_valid;
  logic           e_y_ready;
  logic [W-1:0]   m_data;
  logic           m_valid;
  logic           m_ready;
  logic [IW-1:0]  m_id;
  logic           busy;
  logic           job_done;

  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output e_x_data,
    output e_x_valid,
    input  e_x_ready,
    input  e_y_data,
    input  e_y_valid,
    output e_y_ready,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_id,
    output busy,
    output job_done
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  e_x_data,
    input  e_x_valid,
    output e_x_ready,
    output e_y_data,
    output e_y_valid,
    input  e_y_ready,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_id,
    input  busy,
    input  job_done
  );
endinterface

// File: rtl/conv_rr_sched.sv
// Round-robin job scheduler sharing one conv engine
// between N requesters; one whole job per grant.
module conv_rr_sched #(
  parameter int N = 2,
  parameter int X = 30,
  parameter int F = 9,
  parameter int W = 11
) (
  input logic            clk,
  input logic            reset,
  conv_rr_sched_if.master bus
);
  localparam int R  = X - F + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = (X > 1) ? $clog2(X) : 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(X - 1);
  localparam logic [RW-1:0] R_LAST = RW'(R - 1);
  localparam logic [PW-1:0] G_LAST = PW'(N - 1);
  localparam logic [PW:0]   N_V    = (PW+1)'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_grant;
  logic [XW-1:0]   r_in_cnt;
  logic [RW-1:0]   r_out_cnt;
  logic            r_job_done;

  logic            w_load;
  logic            w_drain;
  logic [W-1:0]    w_sd [N];
  logic            w_gvalid;
  logic [N-1:0]    w_rot;
  logic [PW-1:0]   w_off;
  logic            w_any;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_pick;
  logic [PW-1:0]   w_next_ptr;
  logic [N-1:0]    w_s_ready;
  logic            w_xhs;
  logic            w_yhs;

  assign w_load  = (r_state == S_LOAD);
  assign w_drain = (r_state == S_DRAIN);

  for (genvar g = 0; g < N; g++) begin : g_split
    assign w_sd[g] = bus.s_data[g*W +: W];
  end

  assign w_gvalid = bus.s_valid[r_grant];

  // Rotate so bit 0 is the requester at ptr,
  // then the lowest set bit is the winner.
  assign w_rot = N'({bus.s_valid, bus.s_valid} >> r_ptr);

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = PW'(k);
      end
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_pick = (w_sum >= N_V) ? PW'(w_sum - N_V)
                                 : PW'(w_sum);

  assign w_next_ptr = (r_grant == G_LAST) ? '0
                                          : r_grant + 1'b1;

  always_comb begin
    w_s_ready = '0;
    if (w_load) w_s_ready[r_grant] = bus.e_x_ready;
  end

  assign w_xhs = w_load & w_gvalid & bus.e_x_ready;
  assign w_yhs = w_drain & bus.e_y_valid & bus.m_ready;

  assign bus.s_ready   = w_s_ready;
  assign bus.e_x_data  = w_load ? w_sd[r_grant] : '0;
  assign bus.e_x_valid = w_load & w_gvalid;
  assign bus.e_y_ready = w_drain & bus.m_ready;
  assign bus.m_data    = w_drain ? bus.e_y_data : '0;
  assign bus.m_valid   = w_drain & bus.e_y_valid;
  assign bus.m_id      = r_grant;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.job_done  = r_job_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_job_done <= 1'b0;
    end else begin
      r_job_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_xhs) begin
            if (r_in_cnt == X_LAST) begin
              r_in_cnt <= '0;
              r_state  <= S_DRAIN;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_yhs) begin
            if (r_out_cnt == R_LAST) begin
              r_out_cnt  <= '0;
              r_ptr      <= w_next_ptr;
              r_job_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_rr_sched.sv
// Scoreboard bench for conv_rr_sched: random requesters,
// a behavioural conv engine and a round-robin job model.
module tb_conv_rr_sched;
  localparam int N  = 2;
  localparam int X  = 30;
  localparam int F  = 9;
  localparam int W  = 11;
  localparam int R  = X - F + 1;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_rr_sched_if #(.N(N), .W(W)) u_if ();

  conv_rr_sched #(
    .N(N), .X(X), .F(F), .W(W)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (u_if)
  );

  logic [N-1:0] sv;
  logic [W-1:0] sd [N];
  logic         ex_ready;
  logic         ey_valid;
  logic [W-1:0] ey_data;
  logic         m_rdy;

  assign u_if.s_valid   = sv;
  assign u_if.e_x_ready = ex_ready;
  assign u_if.e_y_valid = ey_valid;
  assign u_if.e_y_data  = ey_data;
  assign u_if.m_ready   = m_rdy;
  for (genvar g = 0; g < N; g++) begin : g_sd
    assign u_if.s_data[g*W +: W] = sd[g];
  end

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rq [N][$];
  logic [W-1:0] mq [N][$];
  exp_t         expq [$];
  int           m_ptr = 0;
  int           acc [N];
  int           pos [N];

  int           bub = 1;
  bit           cons_rand = 1;
  int           stall_at = -1;

  logic [N-1:0] hsr;
  logic         xhs;
  logic         yhs;
  logic [W-1:0] xdat;
  int           tot_beats = 0;

  logic [W-1:0] ex [X];
  int           ecnt;
  int           eout;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  // Engine function: 9-tap filter then ReLU.
  function automatic logic [W-1:0] conv_ref(
      input logic [W-1:0] xs [X], input int k);
    int a;
    logic signed [W-1:0] v;
    a = 0;
    for (int j = 0; j < F; j++) begin
      v = xs[k + j];
      a += (j - 4) * int'(v);
    end
    if (a < 0) a = 0;
    return W'(a);
  endfunction

  task automatic add_job(input int g, input bit seq);
    logic [W-1:0] v;
    for (int i = 0; i < X; i++) begin
      v = seq ? W'(i + 1) : W'($urandom);
      rq[g].push_back(v);
      mq[g].push_back(v);
    end
  endtask

  // Serve pending jobs in round-robin order from m_ptr.
  task automatic plan();
    logic [W-1:0] xs [X];
    exp_t e;
    int g;
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(m_ptr + k) % N].size() >= X)
          g = (m_ptr + k) % N;
      if (g < 0) break;
      for (int i = 0; i < X; i++) xs[i] = mq[g].pop_front();
      for (int k = 0; k < R; k++) begin
        e.id = IW'(g);
        e.d  = conv_ref(xs, k);
        expq.push_back(e);
      end
      m_ptr = (g + 1) % N;
    end
  endtask

  function automatic bit all_sent();
    for (int g = 0; g < N; g++)
      if (rq[g].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (c < 4000 && !(expq.size() == 0 && all_sent())) begin
      @(posedge clk); #2;
      c++;
    end
    chk({nm, "_results_left"}, expq.size(), 0);
    repeat (4) @(posedge clk);
    #2;
    chk({nm, "_idle"}, u_if.busy, 0);
  endtask

  // Requester drivers
  initial begin
    sv = '0;
    for (int g = 0; g < N; g++) begin
      sd[g] = '0; pos[g] = 0; acc[g] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < N; g++) begin
        if (!rst_n) begin
          pos[g] = 0; sv[g] = 1'b0; sd[g] = '0;
        end else begin
          if (hsr[g]) begin
            void'(rq[g].pop_front());
            acc[g]++;
            pos[g] = (pos[g] + 1) % X;
          end
          if (rq[g].size() > 0) begin
            if (pos[g] == 0) sv[g] = 1'b1;
            else if (bub == 2) sv[g] = ~sv[g];
            else sv[g] = ($urandom_range(0, 3) != 0);
            sd[g] = rq[g][0];
          end else begin
            sv[g] = 1'b0; sd[g] = '0;
          end
        end
      end
    end
  end

  // Conv engine model; stray y_valid while collecting
  initial begin
    ecnt = 0; eout = -1;
    ex_ready = 1'b0; ey_valid = 1'b0; ey_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ecnt = 0; eout = -1;
        ex_ready = 1'b0; ey_valid = 1'b0; ey_data = '0;
      end else begin
        if (xhs) begin
          ex[ecnt] = xdat;
          ecnt++;
          if (ecnt == X) begin ecnt = 0; eout = 0; end
        end
        if (yhs && eout >= 0) begin
          eout++;
          if (eout == R) eout = -1;
        end
        if (eout >= 0) begin
          ex_ready = 1'b0;
          if (!(ey_valid && !yhs))
            ey_valid = ($urandom_range(0, 3) != 0);
          ey_data = conv_ref(ex, eout);
        end else begin
          ex_ready = ($urandom_range(0, 4) != 0);
          ey_valid = ($urandom_range(0, 3) == 0);
          ey_data  = W'($urandom);
        end
      end
    end
  end

  // Consumer with one scripted 5-cycle stall
  initial begin
    int stall;
    int used;
    stall = 0; used = -1; m_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_at >= 0 && tot_beats == stall_at
          && used != stall_at) begin
        stall = 5; used = stall_at;
      end
      if (stall > 0) begin
        m_rdy = 1'b0; stall--;
      end else begin
        m_rdy = cons_rand ? ($urandom_range(0, 2) != 0)
                          : 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int   beats;
    bit   jd_exp;
    bit   hold_p;
    logic [W-1:0] hold_d;
    exp_t e;
    beats = 0; jd_exp = 0; hold_p = 0; hold_d = '0;
    hsr = '0; xhs = 0; yhs = 0; xdat = '0;
    forever begin
      @(negedge clk);
      hsr  = u_if.s_valid & u_if.s_ready;
      xhs  = u_if.e_x_valid & u_if.e_x_ready;
      xdat = u_if.e_x_data;
      yhs  = u_if.e_y_valid & u_if.e_y_ready;
      if (!rst_n) begin
        beats = 0; jd_exp = 0; hold_p = 0;
      end else begin
        if (u_if.job_done || jd_exp)
          chk("job_done", u_if.job_done, jd_exp);
        if (jd_exp) chk("busy_after_done", u_if.busy, 0);
        jd_exp = 0;
        if (u_if.s_ready != '0)
          chk("s_ready_grant",
              ($countones(u_if.s_ready) == 1) && u_if.busy, 1);
        if (eout < 0 && u_if.e_y_valid)
          chk("stray_y", {u_if.e_y_ready, u_if.m_valid}, 0);
        if (!u_if.m_ready && u_if.e_y_valid)
          chk("y_backpressure", u_if.e_y_ready, 0);
        if (hold_p && u_if.m_valid)
          chk("m_hold", u_if.m_data, hold_d);
        hold_p = u_if.m_valid && !u_if.m_ready;
        hold_d = u_if.m_data;
        if (u_if.m_valid && u_if.m_ready) begin
          chk("m_expected_avail", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("m_id", u_if.m_id, e.id);
            chk("m_data", u_if.m_data, e.d);
          end
          beats++;
          tot_beats++;
          if (beats == R) begin beats = 0; jd_exp = 1; end
        end
      end
    end
  end

  initial begin
    int base;
    int c;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s_ready", u_if.s_ready, 0);
    chk("rst_e_x_valid", u_if.e_x_valid, 0);
    chk("rst_e_y_ready", u_if.e_y_ready, 0);
    chk("rst_m_valid", u_if.m_valid, 0);
    chk("rst_m_id", u_if.m_id, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_job_done", u_if.job_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: both requesting, two jobs each
    bub = 1; cons_rand = 1;
    add_job(0, 0); add_job(0, 0);
    add_job(1, 0); add_job(1, 0);
    plan();
    wait_done("contention");

    // Single sequential job with a mid-drain stall
    cons_rand = 0;
    stall_at = tot_beats + 10;
    base = acc[0];
    add_job(0, 1);
    plan();
    wait_done("single");
    chk("single_x_beats", acc[0] - base, X);

    // Toggling valid while the other requester waits
    bub = 2; cons_rand = 1;
    base = acc[1];
    add_job(1, 0); add_job(0, 0);
    plan();
    wait_done("bubbles");
    chk("bubble_x_beats", acc[1] - base, X);

    // Lone requesters in turn
    bub = 1;
    add_job(1, 0); plan(); wait_done("skip_r1");
    add_job(0, 0); plan(); wait_done("skip_r0");

    // Abort at sample 12, then a fresh full job
    base = acc[0];
    add_job(0, 0);
    plan();
    c = 0;
    while (c < 3000 && acc[0] - base < 12) begin
      @(posedge clk); #2;
      c++;
    end
    chk("reach_12", acc[0] - base, 12);
    rst_n = 1'b0;
    #1;
    chk("abort_s_ready", u_if.s_ready, 0);
    chk("abort_busy", u_if.busy, 0);
    chk("abort_e_x_valid", u_if.e_x_valid, 0);
    for (int g = 0; g < N; g++) begin
      rq[g].delete(); mq[g].delete();
    end
    expq.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = acc[0];
    add_job(0, 0);
    plan();
    wait_done("post_reset");
    chk("post_reset_x_beats", acc[0] - base, X);
    chk("engine_no_extra", ecnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
